pipelined_adder: RTL

//  Parametrised, pipelined unsigned adder: WIDTH-bit a + b + cin -> WIDTH-bit sum + cout.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder_slice.sv | 17 +
 rtl/pipelined_adder.sv | 103 ++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants, slice-width helper and stage register layout for pipelined_adder.
package adder_pkg;

  localparam int unsigned AdderWidth  = 32;
  localparam int unsigned AdderStages = 4;

  // Bits handled by one pipeline stage; a zero stage count is caught in the top.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  // Stage register layout at the default configuration; the top declares the same
  // shape sized by its own parameters.
  typedef struct packed {
    logic                  valid;
    logic                  carry;
    logic [AdderWidth-1:0] a_rem;
    logic [AdderWidth-1:0] b_rem;
    logic [AdderWidth-1:0] sum_done;
  } adder_stage_t;

endpackage

// File: rtl/adder_slice.sv
// One carry slice: Width-bit combinational add with carry in and carry out.
module adder_slice #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             ci_i,
  output logic [Width-1:0] s_o,
  output logic             co_o
);

  // Ripple add of the slice; top bit of the extended result is the carry out.
  always_comb begin
    {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{Width{1'b0}}, ci_i};
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined unsigned adder: {cout, sum} = a + b + cin, carry chain cut into STAGES slices.
// Stage k adds slice k; upper operand slices ride along skewed, finished sum slices move forward.
// Optional build macro: ADDER_SAT_EN -- saturate sum to all ones when the final carry is set.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = AdderWidth,
  parameter int unsigned STAGES = AdderStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned Slice = slice_width(WIDTH, STAGES);
  localparam int          Last  = (STAGES == 0) ? 0 : int'(STAGES) - 1;

  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be at least 1");
  end
  if ((STAGES != 0) && (WIDTH % STAGES != 0)) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_done;
  } stage_t;

  stage_t           stage_q [STAGES];
  stage_t           stage_d [STAGES];
  stage_t           src     [STAGES];
  logic [Slice-1:0] sl_s    [STAGES];
  logic             sl_co   [STAGES];
  logic             adv;

  // Each stage reads fresh operands (stage 0) or the previous stage register, and adds its slice.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src[k] = '{valid: in_valid, carry: cin, a_rem: a, b_rem: b, sum_done: '0};
    end else begin : g_next
      assign src[k] = stage_q[k-1];
    end

    adder_slice #(
      .Width(Slice)
    ) u_slice (
      .a_i (src[k].a_rem[k*Slice +: Slice]),
      .b_i (src[k].b_rem[k*Slice +: Slice]),
      .ci_i(src[k].carry),
      .s_o (sl_s[k]),
      .co_o(sl_co[k])
    );
  end

  // Whole pipe advances together whenever the output slot is free or being drained.
  always_comb begin
    adv = !stage_q[Last].valid || out_ready;
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k] = stage_q[k];
      if (adv) begin
        stage_d[k]                            = src[k];
        stage_d[k].carry                      = sl_co[k];
        stage_d[k].sum_done[k*Slice +: Slice] = sl_s[k];
`ifdef ADDER_SAT_EN
        if ((k == Last) && sl_co[k]) begin
          stage_d[k].sum_done = '1;
        end
`endif
      end
    end
  end

  // Stage registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = stage_q[Last].valid;
  assign sum       = stage_q[Last].sum_done;
  assign cout      = stage_q[Last].carry;

endmodule
